hazard_sched_unit: RTL and testbench

//  Pipeline hazard controller and multicycle scheduler for the 5-stage scalar/SIMD datapath.
//  - Produces the forwarding selects ForwardAE/BE from the datapath's stage-match flags.
//  - Produces StallF, StallD and FlushD for the datapath, and FlushE for the E-stage control registers.
//  - Owns a counter FSM that freezes the front end while a multicycle vector (FIR MAC) op runs in Execute.

---
 rtl/hazard_sched_unit.sv | 126 ++++++++++++
 tb/tb_hazard_sched_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched_unit.sv
// Hazard controller for the 5-stage datapath: forwarding selects, stall/flush and a vector-op FSM.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_sched_unit #(
    parameter int unsigned VEC_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Match_1E_M,
    input  logic             Match_1E_W,
    input  logic             Match_2E_M,
    input  logic             Match_2E_W,
    input  logic             Match_12D_E,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             VecStartE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             VecBusy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned     CntW    = $clog2(VEC_CYCLES + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(VEC_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic            VecEn   = (VEC_CYCLES > 1);

    typedef enum logic [0:0] {
        StIdle,
        StVec
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            ld_stall;
    logic            pc_pend;

    always_comb begin
        ForwardAE = 2'b00;
        if (Match_1E_M && RegWriteM) begin
            ForwardAE = 2'b10;
        end else if (Match_1E_W && RegWriteW) begin
            ForwardAE = 2'b01;
        end
        ForwardBE = 2'b00;
        if (Match_2E_M && RegWriteM) begin
            ForwardBE = 2'b10;
        end else if (Match_2E_W && RegWriteW) begin
            ForwardBE = 2'b01;
        end
    end

    assign ld_stall = Match_12D_E & MemtoRegE;
    assign pc_pend  = PCSrcD | PCSrcE | PCSrcM;
    assign VecBusy  = (state_q == StVec);

    // A taken branch squashes the vector op entering E, so it never occupies the unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (VecStartE && !BranchTakenE && VecEn) begin
                        state_q <= StVec;
                        cnt_q   <= CntInit;
                    end
                end
                StVec: begin
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The bubble in E keeps the held D instruction from being issued twice.
    assign StallF = ld_stall | pc_pend | VecBusy;
    assign StallD = ld_stall | VecBusy;
    assign FlushD = pc_pend | PCSrcW | BranchTakenE;
    assign FlushE = ld_stall | BranchTakenE | VecBusy;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallD && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (FlushD && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Self-checking bench for hazard_sched_unit: vector table, directed multicycle cases, random vs model.
module tb_hazard_sched_unit;

    localparam int unsigned VEC_CYCLES = 4;
    localparam int unsigned CNT_W      = 4;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct packed {
        logic rst;
        logic m1m, m1w, m2m, m2w, m12de;
        logic rwm, rww, mtr;
        logic pcd, pce, pcm, pcw;
        logic bt, vs;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } vec_t;

    logic             clk;
    in_t              stim;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, FlushD, FlushE, VecBusy;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int checks;
    int errors;

    // Reference model state: cycles of vector occupancy still to come, and event tallies.
    int busy_rem;
    int stall_tally;
    int flush_tally;

    hazard_sched_unit #(
        .VEC_CYCLES(VEC_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (stim.rst),
        .Match_1E_M  (stim.m1m),
        .Match_1E_W  (stim.m1w),
        .Match_2E_M  (stim.m2m),
        .Match_2E_W  (stim.m2w),
        .Match_12D_E (stim.m12de),
        .RegWriteM   (stim.rwm),
        .RegWriteW   (stim.rww),
        .MemtoRegE   (stim.mtr),
        .PCSrcD      (stim.pcd),
        .PCSrcE      (stim.pce),
        .PCSrcM      (stim.pcm),
        .PCSrcW      (stim.pcw),
        .BranchTakenE(stim.bt),
        .VecStartE   (stim.vs),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .VecBusy     (VecBusy),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int fwd_sel(input logic mm, input logic rm, input logic mw, input logic rw);
        if (mm && rm) return 2;
        if (mw && rw) return 1;
        return 0;
    endfunction

    function automatic bit m_busy();
        return !stim.rst && (busy_rem > 0);
    endfunction

    function automatic bit m_ld();
        return stim.m12de && stim.mtr;
    endfunction

    function automatic bit m_pcpend();
        return stim.pcd || stim.pce || stim.pcm;
    endfunction

    function automatic bit m_stalld();
        return m_ld() || m_busy();
    endfunction

    function automatic bit m_flushd();
        return m_pcpend() || stim.pcw || stim.bt;
    endfunction

    task automatic check_model();
        int exp_sc;
        int exp_fc;
`ifdef HAZARD_PERF_EN
        exp_sc = stim.rst ? 0 : stall_tally;
        exp_fc = stim.rst ? 0 : flush_tally;
`else
        exp_sc = 0;
        exp_fc = 0;
`endif
        chk("ForwardAE", int'(ForwardAE), fwd_sel(stim.m1m, stim.rwm, stim.m1w, stim.rww));
        chk("ForwardBE", int'(ForwardBE), fwd_sel(stim.m2m, stim.rwm, stim.m2w, stim.rww));
        chk("VecBusy", int'(VecBusy), int'(m_busy()));
        chk("StallF", int'(StallF), int'(m_ld() || m_pcpend() || m_busy()));
        chk("StallD", int'(StallD), int'(m_stalld()));
        chk("FlushD", int'(FlushD), int'(m_flushd()));
        chk("FlushE", int'(FlushE), int'(m_ld() || stim.bt || m_busy()));
        chk("StallCount", int'(StallCount), exp_sc);
        chk("FlushCount", int'(FlushCount), exp_fc);
    endtask

    task automatic model_update();
        if (stim.rst) begin
            busy_rem    = 0;
            stall_tally = 0;
            flush_tally = 0;
        end else begin
            if (m_stalld() && stall_tally < CNT_MAX) stall_tally++;
            if (m_flushd() && flush_tally < CNT_MAX) flush_tally++;
            if (busy_rem > 0) busy_rem--;
            else if (stim.vs && !stim.bt && VEC_CYCLES > 1) busy_rem = VEC_CYCLES - 1;
        end
    endtask

    // Apply one cycle of inputs; exp_vb >= 0 adds an explicit VecBusy expectation.
    task automatic step(input in_t v, input int exp_vb);
        stim = v;
        @(negedge clk);
        check_model();
        if (exp_vb >= 0) chk("VecBusy_seq", int'(VecBusy), exp_vb);
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic in_t idle_in();
        in_t v;
        v = '0;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        in_t v;
        checks      = 0;
        errors      = 0;
        busy_rem    = 0;
        stall_tally = 0;
        flush_tally = 0;
        stim        = '0;
        stim.rst    = 1'b1;

        for (int i = 0; i < 14; i++) tbl[i] = '0;
        tbl[0].in.m1m = 1; tbl[0].in.rwm = 1; tbl[0].in.m1w = 1; tbl[0].in.rww = 1; tbl[0].fa = 2'b10;
        tbl[1].in.m1w = 1; tbl[1].in.rww = 1; tbl[1].fa = 2'b01;
        tbl[3].in.m1m = 1; tbl[3].in.m1w = 1; tbl[3].in.rww = 1; tbl[3].fa = 2'b01;
        tbl[4].in.m2m = 1; tbl[4].in.rwm = 1; tbl[4].fb = 2'b10;
        tbl[5].in.m2m = 1; tbl[5].in.m2w = 1; tbl[5].in.rww = 1; tbl[5].fb = 2'b01;
        tbl[6].in.m12de = 1; tbl[6].in.mtr = 1;
        tbl[6].sf = 1; tbl[6].sd = 1; tbl[6].fe = 1;
        tbl[7].in.m12de = 1;
        tbl[8].in.pcd = 1; tbl[8].sf = 1; tbl[8].fd = 1;
        tbl[9].in.pcw = 1; tbl[9].fd = 1;
        tbl[10].in.bt = 1; tbl[10].fd = 1; tbl[10].fe = 1;
        tbl[11].in.pce = 1; tbl[11].sf = 1; tbl[11].fd = 1;
        tbl[12].in.pcm = 1; tbl[12].sf = 1; tbl[12].fd = 1;
        tbl[13].in.m12de = 1; tbl[13].in.mtr = 1; tbl[13].in.pcd = 1;
        tbl[13].sf = 1; tbl[13].sd = 1; tbl[13].fd = 1; tbl[13].fe = 1;

        // Reset state
        v = idle_in();
        v.rst = 1'b1;
        #1;
        step(v, 0);
        step(v, 0);

        // Table of combinational cases with the FSM idle
        for (int i = 0; i < 14; i++) begin
            stim = tbl[i].in;
            @(negedge clk);
            chk("tbl_ForwardAE", int'(ForwardAE), int'(tbl[i].fa));
            chk("tbl_ForwardBE", int'(ForwardBE), int'(tbl[i].fb));
            chk("tbl_StallF", int'(StallF), int'(tbl[i].sf));
            chk("tbl_StallD", int'(StallD), int'(tbl[i].sd));
            chk("tbl_FlushD", int'(FlushD), int'(tbl[i].fd));
            chk("tbl_FlushE", int'(FlushE), int'(tbl[i].fe));
            check_model();
            @(posedge clk);
            model_update();
            #1;
        end

        // Vector op occupies E for VEC_CYCLES-1 cycles; a restart inside the window is ignored
        v = idle_in();
        v.vs = 1'b1;
        step(v, 0);
        step(idle_in(), 1);
        step(v, 1);
        step(idle_in(), 1);
        step(idle_in(), 0);
        step(idle_in(), 0);

        // Vector start coinciding with a taken branch: branch wins
        v = idle_in();
        v.vs = 1'b1;
        v.bt = 1'b1;
        stim = v;
        @(negedge clk);
        chk("vs_bt_FlushD", int'(FlushD), 1);
        chk("vs_bt_FlushE", int'(FlushE), 1);
        check_model();
        @(posedge clk);
        model_update();
        #1;
        step(idle_in(), 0);
        step(idle_in(), 0);

        // Reset on the second vector cycle aborts the op
        v = idle_in();
        v.vs = 1'b1;
        step(v, 0);
        step(idle_in(), 1);
        v = idle_in();
        v.rst = 1'b1;
        stim = v;
        @(negedge clk);
        chk("rst_mid_VecBusy", int'(VecBusy), 0);
        chk("rst_mid_StallCount", int'(StallCount), 0);
        check_model();
        @(posedge clk);
        model_update();
        #1;
        step(idle_in(), 0);
        v = idle_in();
        v.m12de = 1'b1;
        v.mtr   = 1'b1;
        for (int i = 0; i < 5; i++) step(v, 0);
        stim = idle_in();
        @(negedge clk);
`ifdef HAZARD_PERF_EN
        chk("five_stalls", int'(StallCount), 5);
`else
        chk("five_stalls", int'(StallCount), 0);
`endif
        check_model();
        @(posedge clk);
        model_update();
        #1;

        // Saturation of the narrow counters
        v = idle_in();
        v.m12de = 1'b1;
        v.mtr   = 1'b1;
        v.pcw   = 1'b1;
        for (int i = 0; i < CNT_MAX + 4; i++) step(v, -1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            v       = '0;
            v.m1m   = 1'($urandom_range(0, 1));
            v.m1w   = 1'($urandom_range(0, 1));
            v.m2m   = 1'($urandom_range(0, 1));
            v.m2w   = 1'($urandom_range(0, 1));
            v.m12de = 1'($urandom_range(0, 1));
            v.rwm   = 1'($urandom_range(0, 1));
            v.rww   = 1'($urandom_range(0, 1));
            v.mtr   = 1'($urandom_range(0, 2) == 0);
            v.pcd   = 1'($urandom_range(0, 5) == 0);
            v.pce   = 1'($urandom_range(0, 5) == 0);
            v.pcm   = 1'($urandom_range(0, 5) == 0);
            v.pcw   = 1'($urandom_range(0, 5) == 0);
            v.bt    = 1'($urandom_range(0, 5) == 0);
            v.vs    = 1'($urandom_range(0, 3) == 0);
            v.rst   = 1'($urandom_range(0, 49) == 0);
            step(v, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
